// File: rtl/reg_file_pkg.sv
// Shared constants, types and address helpers for the multi-port integer register file.
package reg_file_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   xlen_t;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        xlen_t     data;
    } wr_port_t;

    // An address holds real state only if it exists and is not the hardwired zero register.
    function automatic logic addr_live(input int unsigned addr, input int unsigned num_regs,
                                       input logic zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write tracker: one busy bit per register, set by issued producers and
// cleared by writeback, with a per-read-port lookup.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    // Vectors span the full address space so out-of-range addresses index harmlessly.
    localparam int SPAN = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy_d, busy_q;
    logic [SPAN-1:0]     clr_s, set_s, view_s;
    logic [ADDR_W-1:0]   wa_s, ra_s;

    // Next busy state: clears from writeback, then a same-cycle set overrides them.
    always_comb begin
        clr_s = '0;
        set_s = '0;
        wa_s  = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wa_s        = wr_addr[j*ADDR_W +: ADDR_W];
            clr_s[wa_s] = clr_s[wa_s] | (wr_en[j] & addr_live(32'(wa_s), NUM_REGS, ZERO_REG));
        end
        set_s[busy_addr] = busy_set & addr_live(32'(busy_addr), NUM_REGS, ZERO_REG);
        busy_d = (busy_q & ~clr_s[NUM_REGS-1:0]) | set_s[NUM_REGS-1:0];
    end

    // Per-port lookup; with bypass a read sees this cycle's clears but not its sets.
    always_comb begin
        view_s  = '0;
        ra_s    = '0;
        rd_busy = '0;
        view_s[NUM_REGS-1:0] = BYPASS ? (busy_q & ~clr_s[NUM_REGS-1:0]) : busy_q;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_s       = rd_addr[i*ADDR_W +: ADDR_W];
            rd_busy[i] = view_s[ra_s] & addr_live(32'(ra_s), NUM_REGS, ZERO_REG);
        end
    end

    // Busy bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: registered read ports, prioritised write ports,
// optional write-to-read bypass and a pending-write scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr
);

    logic [XLEN-1:0]        regs_q [NUM_REGS];
    logic [XLEN-1:0]        regs_d [NUM_REGS];
    logic [NUM_WR-1:0]      wr_ok_s;
    logic [NUM_RD-1:0]      sb_busy_s;
    logic [ADDR_W-1:0]      ra_s;
    logic [XLEN-1:0]        rd_val_s;
    logic [NUM_RD*XLEN-1:0] rd_data_d, rd_data_q;
    logic [NUM_RD-1:0]      rd_valid_d, rd_valid_q;
    logic [NUM_RD-1:0]      rd_busy_d, rd_busy_q;

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (sb_busy_s)
    );

    // Qualify write ports: dropped for x0 and for addresses beyond the array.
    always_comb begin
        wr_ok_s = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok_s[j] = wr_en[j] &
                         addr_live(32'(wr_addr[j*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_REG);
        end
    end

    // Storage update; ascending port order lets the highest port win a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok_s[j]) begin
                regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*XLEN +: XLEN];
            end else begin
                regs_d[0] = regs_d[0];
            end
        end
    end

    // Read mux with optional forwarding of the winning same-cycle write.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        rd_busy_d  = rd_busy_q;
        ra_s       = '0;
        rd_val_s   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_s     = rd_addr[i*ADDR_W +: ADDR_W];
            rd_val_s = addr_live(32'(ra_s), NUM_REGS, ZERO_REG) ? regs_q[ra_s] : '0;
            for (int j = 0; j < NUM_WR; j++) begin
                rd_val_s = (BYPASS && wr_ok_s[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra_s))
                           ? wr_data[j*XLEN +: XLEN] : rd_val_s;
            end
            if (rd_en[i]) begin
                rd_data_d[i*XLEN +: XLEN] = rd_val_s;
                rd_valid_d[i]             = 1'b1;
                rd_busy_d[i]              = sb_busy_s[i];
            end else begin
                rd_valid_d[i] = 1'b0;
            end
        end
    end

    // Architectural state and registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_busy_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised scoreboard bench for reg_file_mp (2 read, 2 write ports, 24 registers so
// that addresses 24..31 exercise the out-of-range rules).
module tb_reg_file_mp;

    localparam int NREGS = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy_set;
    logic [4:0]  busy_addr;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  b;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_regs [NREGS];
    logic        m_busy [NREGS];
    logic [31:0] m_hold_d [2];
    logic        m_hold_b [2];
    int          checks = 0;
    int          errors = 0;

    reg_file_mp #(
        .XLEN(32), .NUM_REGS(NREGS), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy_set(busy_set), .busy_addr(busy_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic live(input logic [4:0] a);
        return (int'(a) < NREGS) && (a != 5'd0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = 32'd0;
            m_busy[k] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            m_hold_d[i] = 32'd0;
            m_hold_b[i] = 1'b0;
        end
    endtask

    task automatic set_idle();
        rd_en = 2'b00; rd_addr = 10'd0; wr_en = 2'b00; wr_addr = 10'd0;
        wr_data = 64'd0; busy_set = 1'b0; busy_addr = 5'd0;
    endtask

    // One cycle of stimulus: apply at negedge, predict the registered response, advance model.
    task automatic drive(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic bs, input logic [4:0] ba);
        exp_t        e;
        logic [4:0]  ra [2];
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [31:0] val;
        @(negedge clk);
        rd_en = ren; rd_addr = {ra1, ra0}; wr_en = wen; wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0}; busy_set = bs; busy_addr = ba;
        ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
        for (int i = 0; i < 2; i++) begin
            if (ren[i]) begin
                val = 32'd0;
                m_hold_b[i] = 1'b0;
                if (live(ra[i])) begin
                    val = m_regs[ra[i]];
                    m_hold_b[i] = m_busy[ra[i]];
                    for (int j = 0; j < 2; j++) begin
                        if (wen[j] && wa[j] == ra[i]) begin
                            val = wd[j];
                            m_hold_b[i] = 1'b0;
                        end
                    end
                end
                m_hold_d[i] = val;
            end
        end
        e.v = ren; e.d0 = m_hold_d[0]; e.d1 = m_hold_d[1]; e.b = {m_hold_b[1], m_hold_b[0]};
        exp_q.push_back(e);
        for (int j = 0; j < 2; j++) begin
            if (wen[j] && live(wa[j])) begin
                m_regs[wa[j]] = wd[j];
                m_busy[wa[j]] = 1'b0;
            end
        end
        if (bs && live(ba)) m_busy[ba] = 1'b1;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        drive(2'b00, 5'd0, 5'd0, 2'b01, a, 5'd0, d, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        drive(2'b11, a0, a1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic bset(input logic [4:0] a);
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, a);
    endtask

    // Monitor: one expected record per driven cycle, compared just after the capturing edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(mon_e.v));
            check("rd_data0", rd_data[31:0], mon_e.d0);
            check("rd_data1", rd_data[63:32], mon_e.d1);
            check("rd_busy", 32'(rd_busy), 32'(mon_e.b));
        end
    end

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        #3;
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data", rd_data[31:0], 32'd0);
        check("reset_busy", 32'(rd_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wr1(5'd3, 32'h1234_5678);
        rd2(5'd3, 5'd3);
        wr1(5'd7, 32'h1111_1111);
        drive(2'b11, 5'd7, 5'd7, 2'b01, 5'd7, 5'd0, 32'hA5A5_A5A5, 32'd0, 1'b0, 5'd0);
        rd2(5'd7, 5'd3);
        wr1(5'd0, 32'hFFFF_FFFF);
        rd2(5'd0, 5'd0);
        bset(5'd0);
        rd2(5'd0, 5'd7);
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd4, 5'd4, 32'h1, 32'h2, 1'b0, 5'd0);
        rd2(5'd4, 5'd4);
        drive(2'b11, 5'd4, 5'd4, 2'b11, 5'd4, 5'd4, 32'h3, 32'h4, 1'b0, 5'd0);
        bset(5'd9);
        rd2(5'd9, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 5'd0, 32'h77, 32'd0, 1'b1, 5'd9);
        rd2(5'd9, 5'd9);
        wr1(5'd9, 32'h88);
        rd2(5'd9, 5'd9);
        bset(5'd10);
        drive(2'b01, 5'd10, 5'd0, 2'b10, 5'd0, 5'd10, 32'd0, 32'h55, 1'b0, 5'd0);
        wr1(5'd30, 32'hCAFE_F00D);
        bset(5'd30);
        rd2(5'd30, 5'd23);
        drive(2'b00, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        // Asynchronous reset arriving mid-cycle with a read in flight.
        wr1(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        set_idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_data", rd_data[31:0], 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        check("rst_hold_valid", 32'(rd_valid), 32'd0);
        check("rst_hold_data", rd_data[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        rd2(5'd5, 5'd9);

        for (int n = 0; n < 1500; n++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
